// File: rtl/rd_port_arbiter.sv
// Two-requester round-robin arbiter onto a shared read port, with an
// outstanding-read counter and response routing by the tag MSB.
module rd_port_arbiter #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int MAX_OUT     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [ADDR_LMT-1:0]      req0_addr,
    input  logic [MDATA-2:0]         req0_mdata,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_LMT-1:0]      req1_addr,
    input  logic [MDATA-2:0]         req1_mdata,
    output logic                     req1_ready,
    output logic [ADDR_LMT-1:0]      rd_req_addr,
    output logic [MDATA-1:0]         rd_req_mdata,
    output logic                     rd_req_en,
    input  logic                     rd_req_almostfull,
    input  logic                     rd_rsp_valid,
    input  logic [MDATA-1:0]         rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0]   rd_rsp_data,
    output logic                     rsp0_valid,
    output logic [MDATA-2:0]         rsp0_mdata,
    output logic [CACHE_WIDTH-1:0]   rsp0_data,
    output logic                     rsp1_valid,
    output logic [MDATA-2:0]         rsp1_mdata,
    output logic [CACHE_WIDTH-1:0]   rsp1_data,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_underflow
);
    localparam int OCW = $clog2(MAX_OUT) + 1;

    logic                        lg;
    logic                        grant_ok;
    logic                        gnt;
    logic [1:0]                  rsp_v;
    logic [1:0][MDATA-2:0]       rsp_md;
    logic [1:0][CACHE_WIDTH-1:0] rsp_d;

    // Ready is held low during reset so nothing is consumed upstream.
    always_comb begin
        grant_ok   = !rst && !rd_req_almostfull && (outstanding < OCW'(MAX_OUT));
        req0_ready = grant_ok && req0_valid && (!req1_valid || lg);
        req1_ready = grant_ok && req1_valid && (!req0_valid || !lg);
        gnt        = req0_ready || req1_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lg           <= 1'b1;
            rd_req_en    <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_mdata <= '0;
        end else begin
            rd_req_en <= gnt;
            if (gnt) begin
                lg           <= req1_ready;
                rd_req_addr  <= req1_ready ? req1_addr : req0_addr;
                rd_req_mdata <= req1_ready ? {1'b1, req1_mdata} : {1'b0, req0_mdata};
            end
        end
    end

    // A simultaneous grant and response cancel out, even at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            case ({gnt, rd_rsp_valid})
                2'b10: outstanding <= outstanding + OCW'(1);
                2'b01: begin
                    if (outstanding == '0) err_underflow <= 1'b1;
                    else                   outstanding   <= outstanding - OCW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_v  <= '0;
            rsp_md <= '0;
            rsp_d  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                rsp_v[k] <= rd_rsp_valid && (rd_rsp_mdata[MDATA-1] == 1'(k));
                if (rd_rsp_valid && (rd_rsp_mdata[MDATA-1] == 1'(k))) begin
                    rsp_md[k] <= rd_rsp_mdata[MDATA-2:0];
                    rsp_d[k]  <= rd_rsp_data;
                end
            end
        end
    end

    assign rsp0_valid = rsp_v[0];
    assign rsp0_mdata = rsp_md[0];
    assign rsp0_data  = rsp_d[0];
    assign rsp1_valid = rsp_v[1];
    assign rsp1_mdata = rsp_md[1];
    assign rsp1_data  = rsp_d[1];
endmodule

// File: tb/tb_rd_port_arbiter.sv
// Directed self-checking bench for rd_port_arbiter (default parameters).
module tb_rd_port_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [19:0]  req0_addr, req1_addr, rd_req_addr;
    logic [12:0]  req0_mdata, req1_mdata, rsp0_mdata, rsp1_mdata;
    logic [13:0]  rd_req_mdata, rd_rsp_mdata;
    logic         rd_req_en, rd_req_almostfull, rd_rsp_valid;
    logic [511:0] rd_rsp_data, rsp0_data, rsp1_data;
    logic         rsp0_valid, rsp1_valid, err_underflow;
    logic [4:0]   outstanding;

    int errors = 0;
    int checks = 0;
    int n;

    rd_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_mdata(req0_mdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_mdata(req1_mdata), .req1_ready(req1_ready),
        .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
        .rd_req_almostfull(rd_req_almostfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .rsp0_valid(rsp0_valid), .rsp0_mdata(rsp0_mdata), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_mdata(rsp1_mdata), .rsp1_data(rsp1_data),
        .outstanding(outstanding), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = '0; req1_addr = '0; req0_mdata = '0; req1_mdata = '0;
        rd_req_almostfull = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0;
        tick();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_en", rd_req_en, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_rspv", {rsp0_valid, rsp1_valid}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;

        // alternating grants under contention
        req0_addr = 20'h10; req1_addr = 20'h20; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", req0_ready, (i % 2 == 0));
            chk("rr_ready1", req1_ready, (i % 2 == 1));
            tick();
            chk("rr_en", rd_req_en, 1);
            chk("rr_addr", rd_req_addr, (i % 2 == 1) ? 20'h20 : 20'h10);
            chk("rr_id", rd_req_mdata[13], (i % 2 == 1));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("idle_en", rd_req_en, 0);
        chk("hold_addr", rd_req_addr, 20'h20);
        chk("out4", outstanding, 4);

        // response routing, back to back
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'h2005; rd_rsp_data[31:0] = 32'hDEADBEEF;
        tick();
        chk("rsp1_valid", rsp1_valid, 1);
        chk("rsp1_mdata", rsp1_mdata, 13'h0005);
        chk("rsp1_data", rsp1_data[31:0], 32'hDEADBEEF);
        chk("rsp0_quiet", rsp0_valid, 0);
        chk("out3", outstanding, 3);
        rd_rsp_mdata = 14'h0003; rd_rsp_data[31:0] = 32'h12345678;
        tick();
        chk("rsp0_valid", rsp0_valid, 1);
        chk("rsp0_mdata", rsp0_mdata, 13'h0003);
        chk("rsp0_data", rsp0_data[31:0], 32'h12345678);
        chk("rsp1_quiet", rsp1_valid, 0);
        chk("out2", outstanding, 2);
        rd_rsp_mdata = 14'h2002;
        tick();
        tick();
        rd_rsp_valid = 1'b0;
        chk("out0", outstanding, 0);
        tick();
        chk("rsp_idle", {rsp0_valid, rsp1_valid}, 0);
        chk("no_err", err_underflow, 0);

        // grant and response together, then underflow
        req0_valid = 1'b1;
        repeat (3) tick();
        chk("out3b", outstanding, 3);
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'h0001;
        #1;
        chk("both_ready0", req0_ready, 1);
        tick();
        chk("both_out", outstanding, 3);
        req0_valid = 1'b0;
        repeat (3) tick();
        chk("drain_out", outstanding, 0);
        chk("drain_err", err_underflow, 0);
        rd_rsp_mdata = 14'h0009;
        tick();
        rd_rsp_valid = 1'b0;
        chk("uf_out", outstanding, 0);
        chk("uf_err", err_underflow, 1);
        chk("uf_route", rsp0_valid, 1);
        chk("uf_mdata", rsp0_mdata, 13'h0009);

        // almostfull blocking, then fresh-reset priority to requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", err_underflow, 0);
        rd_req_almostfull = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("af_ready", {req0_ready, req1_ready}, 0);
            tick();
            chk("af_en", rd_req_en, 0);
        end
        rd_req_almostfull = 1'b0;
        #1;
        chk("af_drop_r0", req0_ready, 1);
        chk("af_drop_r1", req1_ready, 0);
        tick();
        rd_req_almostfull = 1'b1;
        chk("af_issue_en", rd_req_en, 1);
        chk("af_issue_id", rd_req_mdata[13], 0);
        #1;
        chk("af_rise_ready", {req0_ready, req1_ready}, 0);
        tick();
        chk("af_rise_en", rd_req_en, 0);
        chk("af_out1", outstanding, 1);
        rd_req_almostfull = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // fill to MAX_OUT from requester 1
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'h2000;
        tick();
        rd_rsp_valid = 1'b0;
        chk("fill_start", outstanding, 0);
        req1_valid = 1'b1;
        n = 0;
        repeat (20) begin
            #1;
            if (req1_ready) n++;
            tick();
        end
        chk("fill_grants", n, 16);
        chk("fill_out", outstanding, 16);
        #1;
        chk("full_ready", req1_ready, 0);
        rd_rsp_valid = 1'b1;
        tick();
        rd_rsp_valid = 1'b0;
        chk("full_dec", outstanding, 15);
        n = 0;
        repeat (3) begin
            #1;
            if (req1_ready) n++;
            tick();
        end
        chk("regrant_cnt", n, 1);
        chk("refill_out", outstanding, 16);
        req1_valid = 1'b0;

        // async reset mid-flight at outstanding=5
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'h0007; rd_rsp_data[31:0] = 32'h0000CAFE;
        repeat (11) tick();
        rd_rsp_valid = 1'b0;
        chk("pre_rst_out", outstanding, 5);
        chk("pre_rst_rspv", rsp0_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_out", outstanding, 0);
        chk("arst_rspv", rsp0_valid, 0);
        chk("arst_rspd", rsp0_data[31:0], 0);
        chk("arst_rspm", rsp0_mdata, 0);
        chk("arst_addr", rd_req_addr, 0);
        chk("arst_mdata", rd_req_mdata, 0);
        tick();
        rst = 1'b0;
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'h2004;
        tick();
        rd_rsp_valid = 1'b0;
        chk("post_rst_out", outstanding, 0);
        chk("post_rst_err", err_underflow, 1);
        chk("post_rst_route", rsp1_valid, 1);
        chk("post_rst_mdata", rsp1_mdata, 13'h0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
